// File: rtl/seq_mul_unit_pkg.sv
// Shared definitions for the sequential multiplier and its companion divider:
// default operand width, control-state encoding and iteration-counter type.
package seq_mul_unit_pkg;

  localparam int WL = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [$clog2(WL)-1:0] iter_t;

endpackage

// File: rtl/seq_mul_unit_sign_mag_cond.sv
// Conditional two's-complement negate: y = neg ? -a : a. Serves as abs() on
// operands (neg = sign bit) and as the final product sign fix-up.
module seq_mul_unit_sign_mag_cond #(
  parameter int W = 16
) (
  input  logic         neg_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  // The most negative value maps onto itself, which read as unsigned is its magnitude.
  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier, wl x wl -> 2*wl, signed or unsigned.
// Fixed latency of wl steps; start/busy/done handshake shared with the divider.
module seq_mul_unit
  import seq_mul_unit_pkg::*;
#(
  parameter int wl = WL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            Unsigned,
  input  logic [wl-1:0]   Operand1,
  input  logic [wl-1:0]   Operand2,
  output logic            busy,
  output logic            done,
  output logic [2*wl-1:0] Product
);

  localparam int            IW   = $clog2(wl);
  localparam logic [IW-1:0] LAST = IW'(wl - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [wl-1:0]     mcand_q, mcand_d;
  logic [wl-1:0]     mplier_q, mplier_d;
  logic [wl-1:0]     acc_hi_q, acc_hi_d;
  logic              sign_q, sign_d;
  logic              done_q, done_d;
  logic [2*wl-1:0]   product_q, product_d;

  logic [wl-1:0]     mag1, mag2;
  logic [wl:0]       sum;
  logic [wl-1:0]     acc_hi_nx, mplier_nx;
  logic [2*wl-1:0]   prod_final;

  seq_mul_unit_sign_mag_cond #(.W(wl)) u_abs1 (
    .neg_i (~Unsigned & Operand1[wl-1]),
    .a_i   (Operand1),
    .y_o   (mag1)
  );

  seq_mul_unit_sign_mag_cond #(.W(wl)) u_abs2 (
    .neg_i (~Unsigned & Operand2[wl-1]),
    .a_i   (Operand2),
    .y_o   (mag2)
  );

  seq_mul_unit_sign_mag_cond #(.W(2*wl)) u_fix (
    .neg_i (sign_q),
    .a_i   ({acc_hi_nx, mplier_nx}),
    .y_o   (prod_final)
  );

  // One shift-add step: the carry out of the add becomes the new top bit.
  always_comb begin
    sum       = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_hi_nx = sum[wl:1];
    mplier_nx = {sum[0], mplier_q[wl-1:1]};
  end

  // NOTE: every signal gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_hi_d  = acc_hi_q;
    sign_d    = sign_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          iter_d   = '0;
          mcand_d  = mag1;
          mplier_d = mag2;
          acc_hi_d = '0;
          sign_d   = ~Unsigned & (Operand1[wl-1] ^ Operand2[wl-1]);
        end
      end
      RUN: begin
        acc_hi_d = acc_hi_nx;
        mplier_d = mplier_nx;
        iter_d   = iter_q + IW'(1);
        if (iter_q == LAST) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          product_d = prod_final;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_hi_q  <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_hi_q  <= acc_hi_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed and CRC-driven random checks of seq_mul_unit (wl=16): products,
// fixed 16-cycle latency, busy/done handshake, back-to-back and abort.
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        uns;
  logic [15:0] op1, op2;
  logic        busy, done;
  logic [31:0] product;

  int n_checks = 0;
  int n_fails  = 0;

  seq_mul_unit #(.wl(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Unsigned (uns),
    .Operand1 (op1),
    .Operand2 (op2),
    .busy     (busy),
    .done     (done),
    .Product  (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_next(input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 16; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Called at posedge+1 with busy low; returns at posedge+1 after the accept edge.
  task automatic launch(input logic u, input logic [15:0] a, input logic [15:0] b);
    uns = u; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op1 = 16'hA5A5; op2 = 16'h5A5A; uns = ~u;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL accept_busy: busy=%b required 1", busy);
    end
  endtask

  // Waits for done, checking Product holds its old value meanwhile and the latency.
  task automatic wait_done(input logic [31:0] hold, input int exp_lat, output logic [31:0] p);
    int lat;
    bit stable;
    lat = -1; stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
      if (product !== hold) stable = 1'b0;
    end
    p = product;
    n_checks++;
    if (!stable) begin
      n_fails++;
      $display("FAIL product_hold: Product changed before done, required %h", hold);
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fails++;
      $display("FAIL latency: got %0d cycles (-1 = timeout) required %0d", lat, exp_lat);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL busy_at_done: busy=%b required 0", busy);
    end
  endtask

  task automatic do_op(input string name, input logic u, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    logic [31:0] p;
    launch(u, a, b);
    wait_done(product, 16, p);
    n_checks++;
    if (p !== exp) begin
      n_fails++;
      $display("FAIL %s: Product=%h required %h", name, p, exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s_after: done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; uns = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      n_fails++;
      $display("FAIL reset: busy=%b done=%b Product=%h required 0 0 0", busy, done, product);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    do_op("u_ffff_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    do_op("s_8000_8000", 1'b0, 16'h8000, 16'h8000, 32'h40000000);
    do_op("s_8000_0001", 1'b0, 16'h8000, 16'h0001, 32'hFFFF8000);
    do_op("s_m3_7",      1'b0, 16'hFFFD, 16'h0007, 32'hFFFFFFEB);
    do_op("s_0_8000",    1'b0, 16'h0000, 16'h8000, 32'h00000000);
    do_op("s_m1_m1",     1'b0, 16'hFFFF, 16'hFFFF, 32'h00000001);
    do_op("u_8000_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
  endtask

  task automatic test_busy_ignore;
    logic [31:0] p, hold;
    hold = product;
    launch(1'b1, 16'h0003, 16'h0005);
    repeat (5) @(posedge clk);
    #1;
    uns = 1'b0; op1 = 16'h0FFF; op2 = 16'h0FFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(hold, 10, p);
    n_checks++;
    if (p !== 32'h0000000F) begin
      n_fails++;
      $display("FAIL busy_ignore: Product=%h required 0000000f", p);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] p;
    launch(1'b1, 16'h1234, 16'h0010);
    wait_done(product, 16, p);
    n_checks++;
    if (p !== 32'h00012340) begin
      n_fails++;
      $display("FAIL b2b_first: Product=%h required 00012340", p);
    end
    launch(1'b1, 16'h0007, 16'h0009);
    wait_done(32'h00012340, 16, p);
    n_checks++;
    if (p !== 32'h0000003F) begin
      n_fails++;
      $display("FAIL b2b_second: Product=%h required 0000003f", p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    bit saw_done;
    launch(1'b1, 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      n_fails++;
      $display("FAIL abort: busy=%b done=%b Product=%h required 0 0 0", busy, done, product);
    end
    saw_done = 1'b0;
    repeat (24) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fails++;
      $display("FAIL abort_quiet: done/busy raised after abort, required 0");
    end
  endtask

  task automatic test_random;
    logic [31:0] crc, p, exp, q, r;
    logic [15:0] a, b;
    logic        u;
    crc = 32'hC0FFEE11;
    for (int n = 0; n < 1000; n++) begin
      crc = crc_next(crc); a = crc[15:0];
      crc = crc_next(crc); b = crc[15:0];
      u = crc[20];
      if (n % 50 == 0) b = 16'h8000;
      launch(u, a, b);
      wait_done(product, 16, p);
      if (u) exp = {16'h0, a} * {16'h0, b};
      else   exp = 32'($signed(a) * $signed(b));
      n_checks++;
      if (p !== exp) begin
        n_fails++;
        $display("FAIL rand_prod: u=%b %h*%h Product=%h required %h", u, a, b, p, exp);
      end
      if (b != 16'h0) begin
        if (u) begin
          q = p / {16'h0, b};
          r = p % {16'h0, b};
        end else begin
          q = 32'($signed(p) / $signed({{16{b[15]}}, b}));
          r = 32'($signed(p) % $signed({{16{b[15]}}, b}));
        end
        n_checks++;
        if (q !== (u ? {16'h0, a} : {{16{a[15]}}, a}) || r !== 32'h0) begin
          n_fails++;
          $display("FAIL rand_div: u=%b Product=%h / %h quotient=%h rem=%h required %h 0",
                   u, p, b, q, r, a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
